wbarbiter_rr: RTL and testbench

- N-master Wishbone (pipelined) arbiter for a single shared slave bus; generalises the two-master arbiter to NM masters.
- Zero-latency first grant; round-robin fairness; per-cycle outstanding-request tracking with stall throttling.
- Sits between CPU fetch, load/store, DMA and debug masters and the system interconnect.

---
 rtl/wbarbiter_rr.sv | 158 +++++++++++++++
 tb/tb_wbarbiter_rr.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wbarbiter_rr.sv
// wbarbiter_rr: round-robin arbiter that shares one pipelined Wishbone slave bus among NM masters.
// Optional feature: define WBA_TIMEOUT_EN to abort a cycle whose slave stops acknowledging.
`timescale 1ns/1ps
module wbarbiter_rr #(
    parameter int NM     = 4,
    parameter int AW     = 19,
    parameter int DW     = 32,
    parameter int LGPEND = 4,
    parameter int LGTMO  = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NM-1:0]        i_m_cyc,
    input  logic [NM-1:0]        i_m_stb,
    input  logic [NM-1:0]        i_m_we,
    input  logic [NM*AW-1:0]     i_m_adr,
    input  logic [NM*DW-1:0]     i_m_dat,
    input  logic [NM*(DW/8)-1:0] i_m_sel,
    output logic [NM-1:0]        o_m_ack,
    output logic [NM-1:0]        o_m_stall,
    output logic [NM-1:0]        o_m_err,
    output logic                 o_cyc,
    output logic                 o_stb,
    output logic                 o_we,
    output logic [AW-1:0]        o_adr,
    output logic [DW-1:0]        o_dat,
    output logic [DW/8-1:0]      o_sel,
    input  logic                 i_ack,
    input  logic                 i_stall,
    input  logic                 i_err
);
    localparam int IW = $clog2(NM);
    localparam int SW = DW / 8;
    localparam logic [LGPEND:0] PEND_ONE  = {{LGPEND{1'b0}}, 1'b1};
    localparam logic [LGPEND:0] PEND_FULL = {1'b1, {LGPEND{1'b0}}};
    localparam logic [NM-1:0]   GRANT_ONE = {{(NM-1){1'b0}}, 1'b1};

    logic            r_cyc_q, r_cyc_d;
    logic [NM-1:0]   r_grant_q, r_grant_d;
    logic [IW-1:0]   r_last_q, r_last_d;
    logic [LGPEND:0] pending_q, pending_d;

    logic [NM-1:0] blocked;
    logic          tmo_fire;
    logic          found;
    logic [IW-1:0] search_idx, cand, low_idx, mux_idx;
    logic          cyc, full, pend_nz, rsp_ok, accept, retire;
    logic [NM-1:0] own;

    if (LGTMO < 1) begin : g_lgtmo_unsized
    end

    // The search begins just after the most recent grant so every requester gets a turn.
    always_comb begin
        found      = 1'b0;
        search_idx = '0;
        cand       = '0;
        for (int i = 1; i <= NM; i++) begin
            cand = IW'((int'(r_last_q) + i) % NM);
            if (!found && i_m_cyc[cand] && !blocked[cand]) begin
                found      = 1'b1;
                search_idx = cand;
            end
        end
        low_idx = '0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (i_m_cyc[IW'(i)]) low_idx = IW'(i);
        end
    end

    always_comb begin
        full    = (pending_q == PEND_FULL);
        pend_nz = (pending_q != '0);
        if (!i_rst_n)     cyc = 1'b0;
        else if (r_cyc_q) cyc = |(r_grant_q & i_m_cyc & ~blocked);
        else              cyc = found;

        if (!cyc) begin
            own     = '0;
            mux_idx = low_idx;
        end else if (r_cyc_q) begin
            own     = r_grant_q;
            mux_idx = r_last_q;
        end else begin
            own     = GRANT_ONE << search_idx;
            mux_idx = search_idx;
        end

        o_cyc  = cyc;
        o_stb  = cyc && i_m_stb[mux_idx] && !full;
        o_we   = i_m_we[mux_idx];
        o_adr  = i_m_adr[int'(mux_idx)*AW +: AW];
        o_dat  = i_m_dat[int'(mux_idx)*DW +: DW];
        o_sel  = i_m_sel[int'(mux_idx)*SW +: SW];

        // Responses with nothing outstanding are stray and are dropped.
        rsp_ok    = cyc && pend_nz;
        accept    = o_stb && !i_stall;
        retire    = rsp_ok && (i_ack || i_err);
        o_m_ack   = own & {NM{i_ack && rsp_ok}};
        o_m_stall = ~own | {NM{i_stall || full}};

        r_cyc_d   = cyc;
        r_grant_d = own;
        r_last_d  = (cyc && !r_cyc_q) ? search_idx : r_last_q;
        pending_d = pending_q;
        if (!cyc)                   pending_d = '0;
        else if (accept && !retire) pending_d = pending_q + PEND_ONE;
        else if (retire && !accept) pending_d = pending_q - PEND_ONE;
    end

    assign o_m_err = own & {NM{(i_err && rsp_ok) || tmo_fire}};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc_q   <= 1'b0;
            r_grant_q <= '0;
            r_last_q  <= IW'(NM - 1);
            pending_q <= '0;
        end else begin
            r_cyc_q   <= r_cyc_d;
            r_grant_q <= r_grant_d;
            r_last_q  <= r_last_d;
            pending_q <= pending_d;
        end
    end

`ifdef WBA_TIMEOUT_EN
    // A timed-out owner stays locked out until it drops i_m_cyc on its own.
    logic [LGTMO-1:0] tmo_q, tmo_d;
    logic [NM-1:0]    blocked_q, blocked_d;

    always_comb begin
        tmo_fire = rsp_ok && !i_ack && !i_err && (tmo_q == '1);
        tmo_d    = tmo_q;
        if (!cyc || i_ack || i_err) tmo_d = '0;
        else if (pend_nz)           tmo_d = tmo_q + LGTMO'(1);
        blocked_d = blocked_q & i_m_cyc;
        if (tmo_fire) blocked_d = blocked_d | r_grant_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q     <= '0;
            blocked_q <= '0;
        end else begin
            tmo_q     <= tmo_d;
            blocked_q <= blocked_d;
        end
    end

    assign blocked = blocked_q;
`else
    assign tmo_fire = 1'b0;
    assign blocked  = '0;
`endif

endmodule

// File: tb/tb_wbarbiter_rr.sv
// Scoreboard bench for wbarbiter_rr (default build, NM=4): directed grant, stall, pending and reset scenarios.
`timescale 1ns/1ps
module tb_wbarbiter_rr;
   localparam int NM     = 4;
   localparam int AW     = 19;
   localparam int DW     = 32;
   localparam int LGPEND = 4;
   localparam int SW     = DW / 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic [NM-1:0]    m_cyc, m_stb, m_we;
   logic [NM*AW-1:0] m_adr;
   logic [NM*DW-1:0] m_dat;
   logic [NM*SW-1:0] m_sel;
   logic [NM-1:0]    m_ack, m_stall, m_err;
   logic             o_cyc, o_stb, o_we;
   logic [AW-1:0]    o_adr;
   logic [DW-1:0]    o_dat;
   logic [SW-1:0]    o_sel;
   logic             s_ack   = 1'b0;
   logic             s_stall = 1'b0;
   logic             s_err   = 1'b0;

   typedef struct packed {
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [SW-1:0] sel;
      logic          we;
   } txn_t;

   txn_t expQ[$];
   txn_t expTxn;
   int   testsRun = 0;
   int   testsFailed = 0;

   wbarbiter_rr #(.NM(NM), .AW(AW), .DW(DW), .LGPEND(LGPEND), .LGTMO(10)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
      .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
      .o_m_ack(m_ack), .o_m_stall(m_stall), .o_m_err(m_err),
      .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
      .o_adr(o_adr), .o_dat(o_dat), .o_sel(o_sel),
      .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err)
   );

   always #5 clk = ~clk;

   // Each master presents a fixed, distinguishable address, byte-select and direction.
   function automatic logic [AW-1:0] mAdr(input int m);
      return AW'(32'h4000 + m * 32'h111);
   endfunction

   function automatic logic [SW-1:0] mSel(input int m);
      return SW'(1 << m);
   endfunction

   function automatic logic mWe(input int m);
      return m[0];
   endfunction

   task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic [DW-1:0] dat);
      m_cyc[m]            = cyc;
      m_stb[m]            = stb;
      m_we[m]             = mWe(m);
      m_adr[m*AW +: AW]   = mAdr(m);
      m_dat[m*DW +: DW]   = dat;
      m_sel[m*SW +: SW]   = mSel(m);
   endtask

   task automatic expectTxn(input int m, input logic [DW-1:0] dat);
      txn_t t;
      t.adr = mAdr(m);
      t.dat = dat;
      t.sel = mSel(m);
      t.we  = mWe(m);
      expQ.push_back(t);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Every strobe the slave accepts must match the oldest queued expectation.
   always @(negedge clk) begin
      if (o_stb && !s_stall) begin
         testsRun++;
         if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL txn_unexpected: got adr %h dat %h, expected no strobe", o_adr, o_dat);
         end else begin
            expTxn = expQ.pop_front();
            if ({o_adr, o_dat, o_sel, o_we} !== expTxn) begin
               testsFailed++;
               $display("[TB] FAIL txn_data: got adr %h dat %h sel %h we %b, expected adr %h dat %h sel %h we %b",
                        o_adr, o_dat, o_sel, o_we, expTxn.adr, expTxn.dat, expTxn.sel, expTxn.we);
            end
         end
      end
   end

   initial begin
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;

      // Reset held with every master requesting and a stray ack on the bus.
      for (int m = 0; m < NM; m++) applyStimulus(m, 1'b1, 1'b1, 32'hA0 + m);
      s_ack = 1'b1;
      @(negedge clk);
      checkOutput("rst_cyc",   32'(o_cyc),   32'h0);
      checkOutput("rst_stb",   32'(o_stb),   32'h0);
      checkOutput("rst_stall", 32'(m_stall), 32'hF);
      checkOutput("rst_ack",   32'(m_ack),   32'h0);
      checkOutput("rst_err",   32'(m_err),   32'h0);

      // All four request together: strict rotation 0,1,2,3 with one idle clock between.
      tick;
      s_ack = 1'b0;
      expectTxn(0, 32'hA0);
      rst_n = 1'b1;
      for (int k = 0; k < NM; k++) begin
         @(negedge clk);
         checkOutput("rot_cyc",   32'(o_cyc),   32'h1);
         checkOutput("rot_owner", 32'(m_stall), 32'hF ^ (32'h1 << k));
         tick;
         applyStimulus(k, 1'b0, 1'b0, '0);
         @(negedge clk);
         checkOutput("rot_gap", 32'(o_cyc), 32'h0);
         tick;
         if (k < NM - 1) expectTxn(k + 1, 32'hA0 + k + 1);
      end

      // Lone master 2 is granted in the same clock it asks.
      applyStimulus(2, 1'b1, 1'b1, 32'hB2);
      expectTxn(2, 32'hB2);
      @(negedge clk);
      checkOutput("solo_cyc",   32'(o_cyc),   32'h1);
      checkOutput("solo_adr",   32'(o_adr),   32'(mAdr(2)));
      checkOutput("solo_stall", 32'(m_stall), 32'hB);
      tick;
      applyStimulus(2, 1'b0, 1'b0, '0);
      @(negedge clk);
      checkOutput("solo_release", 32'(o_cyc), 32'h0);
      tick;

      // Master 1 streams strobes with acks withheld while master 0 waits for 50 clocks.
      for (int c = 0; c < 50; c++) begin
         applyStimulus(1, 1'b1, (c <= 21), 32'h1000 + c);
         if (c < 16 || c == 21) expectTxn(1, 32'h1000 + c);
         if (c == 1) applyStimulus(0, 1'b1, 1'b0, '0);
         s_ack = (c == 20);
         @(negedge clk);
         checkOutput("wait_stall0", 32'(m_stall[0]), 32'h1);
         checkOutput("wait_ack0",   32'(m_ack[0]),   32'h0);
         if (c >= 16 && c <= 20) begin
            checkOutput("full_stb",    32'(o_stb),      32'h0);
            checkOutput("full_stall1", 32'(m_stall[1]), 32'h1);
         end
         if (c == 20) checkOutput("ack_route",   32'(m_ack),      32'h2);
         if (c == 21) checkOutput("refill_stb",  32'(o_stb),      32'h1);
         if (c == 22) checkOutput("refill_full", 32'(m_stall[1]), 32'h1);
         tick;
      end
      s_ack = 1'b0;

      // Master 1 releases: one idle clock, then master 0 owns the bus.
      applyStimulus(1, 1'b0, 1'b0, '0);
      @(negedge clk);
      checkOutput("handoff_gap",    32'(o_cyc),      32'h0);
      checkOutput("handoff_stall0", 32'(m_stall[0]), 32'h1);
      tick;
      s_ack = 1'b1;
      @(negedge clk);
      checkOutput("handoff_grant", 32'(m_stall), 32'hE);
      checkOutput("stray_ack",     32'(m_ack),   32'h0);
      tick;
      s_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 1'b1, 1'b1, 32'h3000 + i);
         expectTxn(0, 32'h3000 + i);
         tick;
      end
      applyStimulus(0, 1'b1, 1'b0, '0);
      s_err = 1'b1;
      @(negedge clk);
      checkOutput("err_route", 32'(m_err), 32'h1);
      tick;
      s_err = 1'b0;

      // Asynchronous reset with five requests outstanding abandons the cycle at once.
      applyStimulus(3, 1'b1, 1'b0, '0);
      s_ack = 1'b1;
      rst_n = 1'b0;
      #1;
      checkOutput("areset_cyc",   32'(o_cyc),   32'h0);
      checkOutput("areset_stb",   32'(o_stb),   32'h0);
      checkOutput("areset_stall", 32'(m_stall), 32'hF);
      checkOutput("areset_ack",   32'(m_ack),   32'h0);
      tick;
      s_ack = 1'b0;
      for (int r = 0; r <= 16; r++) begin
         applyStimulus(0, 1'b1, 1'b1, 32'h4000 + r);
         if (r < 16) expectTxn(0, 32'h4000 + r);
         if (r == 0) rst_n = 1'b1;
         @(negedge clk);
         if (r == 0)  checkOutput("post_reset_grant", 32'(m_stall), 32'hE);
         if (r == 16) checkOutput("post_reset_full",  32'(o_stb),   32'h0);
         tick;
      end

      for (int m = 0; m < NM; m++) applyStimulus(m, 1'b0, 1'b0, '0);
      tick;
      tick;
      checkOutput("sb_drain", 32'(expQ.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
